// File: rtl/train_detect.sv
// Track-sensor front end: sync, debounce and axle counting.
// Drives the semaphore train input, with a latched fault and a watchdog.
module train_detect #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 8,
    parameter int TIMEOUT    = 1000
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             sens_in,
    input  logic             sens_out,
    input  logic             fault_clr,
    output logic             train,
    output logic [CNT_W-1:0] axle_cnt,
    output logic             fault,
    output logic [1:0]       fault_code
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        OCCUPIED,
        FAULTED
    } state_t;

    // bit 0 = entry sensor, bit 1 = exit sensor
    logic [1:0]    sync1, sync2;
    logic [1:0]    filt, filt_d;
    logic [1:0]    pulse;
    logic [DW-1:0] deb_cnt [2];

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       code, code_n;
    logic [WW-1:0]    wd, wd_n;
    logic             inc, dec, ovf, unf;

    assign inc = pulse[0];
    assign dec = pulse[1];

    // Two-flop synchronisers and rising-edge pulse registers
    always_ff @(posedge clk) begin
        if (!clrn) begin
            sync1  <= '0;
            sync2  <= '0;
            filt_d <= '0;
            pulse  <= '0;
        end else begin
            sync1  <= {sens_out, sens_in};
            sync2  <= sync1;
            filt_d <= filt;
            pulse  <= filt & ~filt_d;
        end
    end

    // Debounce: filtered level follows after DEB_CYCLES stable mismatches
    always_ff @(posedge clk) begin
        if (!clrn) begin
            filt       <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    filt[i]    <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Next count, fault detection, watchdog and state transitions
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        code_n  = code;
        wd_n    = '0;
        ovf     = 1'b0;
        unf     = 1'b0;
        if (inc && !dec) begin
            if (&cnt) ovf = 1'b1;
            else      cnt_n = cnt + 1'b1;
        end else if (dec && !inc) begin
            if (cnt == '0) unf = 1'b1;
            else           cnt_n = cnt - 1'b1;
        end
        if (fault_clr) begin
            state_n = IDLE;
            cnt_n   = '0;
            code_n  = 2'b00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ovf || unf) begin
                        state_n = FAULTED;
                        code_n  = unf ? 2'b01 : 2'b10;
                    end else if (cnt_n != '0) begin
                        state_n = OCCUPIED;
                    end
                end
                OCCUPIED: begin
                    if (ovf || unf) begin
                        state_n = FAULTED;
                        code_n  = unf ? 2'b01 : 2'b10;
                    end else if (cnt_n == '0) begin
                        state_n = IDLE;
                    end else if (inc || dec) begin
                        wd_n = '0;
                    end else if (wd == WD_LAST) begin
                        state_n = FAULTED;
                        code_n  = 2'b11;
                    end else begin
                        wd_n = wd + 1'b1;
                    end
                end
                FAULTED: begin
                    state_n = FAULTED;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state <= IDLE;
            cnt   <= '0;
            code  <= 2'b00;
            wd    <= '0;
            train <= 1'b0;
            fault <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            code  <= code_n;
            wd    <= wd_n;
            train <= (state_n != IDLE);
            fault <= (state_n == FAULTED);
        end
    end

    assign axle_cnt   = cnt;
    assign fault_code = code;

endmodule

// File: tb/tb_train_detect.sv
// Bench for train_detect: directed scenarios plus random sensor traffic,
// compared every cycle against a window-based behavioural model.
module tb_train_detect;

    localparam int DEB     = 4;
    localparam int CW      = 8;
    localparam int TMO     = 1000;
    localparam int MAXC    = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          clrn = 1'b0;
    logic          sens_in = 1'b0;
    logic          sens_out = 1'b0;
    logic          fault_clr = 1'b0;
    logic          train;
    logic [CW-1:0] axle_cnt;
    logic          fault;
    logic [1:0]    fault_code;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    train_detect #(
        .DEB_CYCLES(DEB),
        .CNT_W(CW),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .clrn(clrn),
        .sens_in(sens_in),
        .sens_out(sens_out),
        .fault_clr(fault_clr),
        .train(train),
        .axle_cnt(axle_cnt),
        .fault(fault),
        .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model.
    // raw_d2 is the raw sample two edges back (what the debouncer sees);
    // win holds the last DEB such samples; the filtered level flips when
    // every sample in the window disagrees with it. A filtered rise moves
    // the count two edges later. State is derived: faulted, else count!=0.
    bit raw_d1 [2];
    bit raw_d2 [2];
    bit win0 [$];
    bit win1 [$];
    bit m_filt [2];
    bit rose1 [2];
    bit rose2 [2];
    int m_count;
    bit m_faulted;
    int m_code;
    int m_idle;

    bit a, b, occ_old, alldiff, v;
    int fc;

    always @(posedge clk) begin
        if (!clrn) begin
            win0.delete();
            win1.delete();
            for (int i = 0; i < DEB; i++) begin
                win0.push_back(1'b0);
                win1.push_back(1'b0);
            end
            for (int i = 0; i < 2; i++) begin
                raw_d1[i] = 0; raw_d2[i] = 0; m_filt[i] = 0;
                rose1[i] = 0; rose2[i] = 0;
            end
            m_count = 0; m_faulted = 0; m_code = 0; m_idle = 0;
        end else begin
            a = rose2[0];
            b = rose2[1];
            occ_old = !m_faulted && m_count != 0;
            if (fault_clr) begin
                m_count = 0; m_faulted = 0; m_code = 0; m_idle = 0;
            end else begin
                fc = 0;
                if (a && !b) begin
                    if (m_count == MAXC) fc = 2; else m_count++;
                end else if (b && !a) begin
                    if (m_count == 0) fc = 1; else m_count--;
                end
                if (!m_faulted) begin
                    if (fc != 0) begin
                        m_faulted = 1; m_code = fc;
                    end else if (occ_old && m_count != 0 && !(a || b)) begin
                        if (m_idle == TMO - 1) begin
                            m_faulted = 1; m_code = 3;
                        end else begin
                            m_idle++;
                        end
                    end
                end
                if (m_faulted || m_count == 0 || a || b) m_idle = 0;
            end
            rose2 = rose1;
            for (int i = 0; i < 2; i++) begin
                v = raw_d2[i];
                alldiff = 1;
                if (i == 0) begin
                    void'(win0.pop_front()); win0.push_back(v);
                    foreach (win0[k]) if (win0[k] == m_filt[i]) alldiff = 0;
                end else begin
                    void'(win1.pop_front()); win1.push_back(v);
                    foreach (win1[k]) if (win1[k] == m_filt[i]) alldiff = 0;
                end
                rose1[i] = 0;
                if (alldiff) begin
                    m_filt[i] = ~m_filt[i];
                    rose1[i] = m_filt[i];
                end
            end
            raw_d2 = raw_d1;
            raw_d1[0] = sens_in;
            raw_d1[1] = sens_out;
        end
    end

    // Cycle-by-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("train", int'(train), int'(m_faulted || m_count != 0));
            chk("fault", int'(fault), int'(m_faulted));
            chk("fault_code", int'(fault_code), m_code);
            chk("axle_cnt", int'(axle_cnt), m_count);
        end
    end

    task automatic axle(input bit exit_s, input int hi, input int lo);
        @(negedge clk);
        if (exit_s) sens_out = 1'b1; else sens_in = 1'b1;
        repeat (hi) @(negedge clk);
        if (exit_s) sens_out = 1'b0; else sens_in = 1'b0;
        repeat (lo - 1) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        chk_en = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_train", int'(train), 0);
        chk("rst_axle", int'(axle_cnt), 0);
        chk("rst_fault", int'(fault), 0);

        // glitch shorter than the debounce window
        sens_in = 1'b1;
        repeat (3) @(negedge clk);
        sens_in = 1'b0;
        repeat (15) @(negedge clk);
        chk("glitch_axle", int'(axle_cnt), 0);
        chk("glitch_train", int'(train), 0);

        // latency: first sampled high at edge 0, train after edge 7
        @(negedge clk);
        sens_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (k == 5) sens_in = 1'b0;
            if (k == 6) chk("lat_train_e6", int'(train), 0);
            if (k == 7) begin
                chk("lat_train_e7", int'(train), 1);
                chk("lat_axle_e7", int'(axle_cnt), 1);
            end
        end
        repeat (6) @(negedge clk);
        axle(0, 6, 10);
        chk("axle_2", int'(axle_cnt), 2);
        axle(1, 6, 10);
        chk("axle_1", int'(axle_cnt), 1);
        axle(1, 6, 10);
        chk("axle_0", int'(axle_cnt), 0);
        chk("axle_0_train", int'(train), 0);

        // underflow then clear
        axle(1, 6, 10);
        chk("unf_fault", int'(fault), 1);
        chk("unf_code", int'(fault_code), 1);
        chk("unf_train", int'(train), 1);
        chk("unf_axle", int'(axle_cnt), 0);
        @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        chk("clr_train", int'(train), 0);
        chk("clr_fault", int'(fault), 0);
        chk("clr_code", int'(fault_code), 0);

        // watchdog
        axle(0, 6, 6);
        repeat (TMO + 10) @(negedge clk);
        chk("wd_code", int'(fault_code), 3);
        chk("wd_train", int'(train), 1);
        clrn = 1'b0;
        @(negedge clk);
        chk("rst_flt_train", int'(train), 0);
        chk("rst_flt_fault", int'(fault), 0);
        chk("rst_flt_code", int'(fault_code), 0);
        chk("rst_flt_axle", int'(axle_cnt), 0);
        clrn = 1'b1;
        repeat (3) @(negedge clk);

        // simultaneous entry and exit edges with count 2
        axle(0, 6, 8);
        axle(0, 6, 8);
        @(negedge clk);
        sens_in = 1'b1;
        sens_out = 1'b1;
        repeat (6) @(negedge clk);
        sens_in = 1'b0;
        sens_out = 1'b0;
        repeat (10) @(negedge clk);
        chk("align_axle", int'(axle_cnt), 2);
        chk("align_fault", int'(fault), 0);
        @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        chk("sect_reset_axle", int'(axle_cnt), 0);

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if ($urandom_range(5) == 0) sens_in = ~sens_in;
            if ($urandom_range(6) == 0) sens_out = ~sens_out;
            fault_clr = ($urandom_range(299) == 0);
            clrn = ($urandom_range(799) != 0);
        end
        @(negedge clk);
        clrn = 1'b1;
        fault_clr = 1'b0;
        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
